// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types for the PS/2 receive path: the byte type and the frame FSM state.
`timescale 1ns/1ps
package ps2_rx_fifo_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_rx_fifo_fifo_sync.sv
// fifo_sync: single-clock first-word fall-through FIFO with occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// When the FIFO is empty, data_o holds the last byte that was popped.
`timescale 1ns/1ps
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push, do_pop;

    // Flag and handshake decode
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        // A push into a full FIFO is still accepted when a pop frees a slot the same cycle
        do_push = push_i && (!full_o || do_pop);
        count_o = wr_ptr_q - rd_ptr_q;
        data_o  = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Storage array, written on accepted pushes (no reset needed)
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer and held-output registers
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a ready/valid byte FIFO.
// Pins are synchronised (2 flops), glitch filtered, and framed by a small FSM.
// Optional build macro PS2_RX_ERR_COUNT_EN adds a saturating 16-bit error counter.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (sampled 0)
//   SHIFT  | receiving 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then push or flag an error
`timescale 1ns/1ps
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       ps2_clk_async_i,
    input  logic                       ps2_data_async_i,
    output byte_t                      data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       parity_err_o,
    output logic                       frame_err_o,
    output logic                       overflow_o
`ifdef PS2_RX_ERR_COUNT_EN
   ,output logic [15:0]                err_count_o
`endif
);

    localparam int FW = $clog2(FILTER_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_clk_q, filt_data_q;
    logic [FW-1:0] fcnt_clk_q, fcnt_data_q;
    logic          clk_flip, data_flip;
    logic          fall_q;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt_q;
    byte_t         shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          timeout;

    logic          push_d, perr_d, ferr_d;
    logic          push_q, perr_q, ferr_q;
    logic          fifo_full, fifo_empty, fifo_pop;

    // Two-flop synchronisers; lines idle high
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_async_i};
            data_sync_q <= {data_sync_q[0], ps2_data_async_i};
        end
    end

    // A filtered line flips on the FILTER_CYCLES-th consecutive differing sample
    always_comb begin
        clk_flip  = (clk_sync_q[1] != filt_clk_q) && (fcnt_clk_q == FILT_LAST);
        data_flip = (data_sync_q[1] != filt_data_q) && (fcnt_data_q == FILT_LAST);
    end

    // Glitch filters and the registered falling-edge strobe
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            filt_clk_q  <= 1'b1;
            filt_data_q <= 1'b1;
            fcnt_clk_q  <= '0;
            fcnt_data_q <= '0;
            fall_q      <= 1'b0;
        end else begin
            if (clk_sync_q[1] == filt_clk_q || clk_flip) fcnt_clk_q <= '0;
            else                                         fcnt_clk_q <= fcnt_clk_q + FW'(1);
            if (data_sync_q[1] == filt_data_q || data_flip) fcnt_data_q <= '0;
            else                                            fcnt_data_q <= fcnt_data_q + FW'(1);
            if (clk_flip)  filt_clk_q  <= ~filt_clk_q;
            if (data_flip) filt_data_q <= ~filt_data_q;
            // fall_q is high in the first cycle the filtered clock reads 0
            fall_q <= clk_flip && filt_clk_q;
        end
    end

    // Frame watchdog: reloads on every fall and in IDLE, expires at zero
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            tmo_q <= TMO_LOAD;
        end else if (fall_q || state_q == IDLE) begin
            tmo_q <= TMO_LOAD;
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - TW'(1);
        end
    end

    // A fall in the same cycle takes priority over an expiring watchdog
    assign timeout = (state_q != IDLE) && !fall_q && (tmo_q == '0);

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM next-state logic, advancing only on fall_q
    always_comb begin
        state_d = state_q;
        if (fall_q) begin
            unique case (state_q)
                IDLE:    if (!filt_data_q) state_d = SHIFT;
                SHIFT:   if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    // FSM outputs: one verdict per frame, registered into pulses below
    always_comb begin
        push_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (fall_q && state_q == STOP) begin
            if (!filt_data_q)                 ferr_d = 1'b1;
            else if (^{shift_q, par_q} != 1'b1) perr_d = 1'b1;
            else                              push_d = 1'b1;
        end else if (timeout) begin
            ferr_d = 1'b1;
        end
    end

    // Frame datapath: bit counter, shift register, parity capture
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else if (fall_q) begin
            unique case (state_q)
                IDLE:   bit_cnt_q <= '0;
                SHIFT: begin
                    shift_q   <= {filt_data_q, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                PARITY: par_q <= filt_data_q;
                default: ;
            endcase
        end
    end

    // Result pulses, one cycle after the stop-bit fall
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            push_q <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            push_q <= push_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
        end
    end

    assign fifo_pop     = ready_i && !fifo_empty;
    assign valid_o      = !fifo_empty;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overflow_o   = push_q && fifo_full && !fifo_pop;

    fifo_sync #(
        .WIDTH ($bits(byte_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (push_q),
        .data_i   (shift_q),
        .pop_i    (fifo_pop),
        .data_o   (data_o),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (count_o)
    );

`ifdef PS2_RX_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of all error pulses
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            err_cnt_q <= '0;
        end else if ((perr_q || ferr_q || overflow_o) && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good frames, parity error, glitch, timeout,
// overflow and reset mid-frame, all with hand-computed expectations.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 4;
    localparam int FILT    = 8;
    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       perr, ferr, ovf;
`ifdef PS2_RX_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;
    int b_perr, b_ferr, b_ovf;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH          (DEPTH),
        .FILTER_CYCLES  (FILT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .reset_ni         (reset_n),
        .ps2_clk_async_i  (ps2_clk),
        .ps2_data_async_i (ps2_data),
        .data_o           (data),
        .valid_o          (valid),
        .ready_i          (ready),
        .count_o          (count),
        .parity_err_o     (perr),
        .frame_err_o      (ferr),
        .overflow_o       (ovf)
`ifdef PS2_RX_ERR_COUNT_EN
       ,.err_count_o      (err_count)
`endif
    );

    always @(posedge clk) begin
        if (perr) n_perr <= n_perr + 1;
        if (ferr) n_ferr <= n_ferr + 1;
        if (ovf)  n_ovf  <= n_ovf + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #500;
        ps2_clk = 1'b0;
        #1000;
        ps2_clk = 1'b1;
        #500;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        wait_cycles(20);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic snap_errs();
        b_perr = n_perr;
        b_ferr = n_ferr;
        b_ovf  = n_ovf;
    endtask

    task automatic chk_errs(input string tag, input int ep, input int ef, input int eo);
        chk({tag, ".perr"}, 32'(n_perr - b_perr), 32'(ep));
        chk({tag, ".ferr"}, 32'(n_ferr - b_ferr), 32'(ef));
        chk({tag, ".ovf"},  32'(n_ovf - b_ovf),   32'(eo));
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".data"},  32'(data),  32'(exp));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b0;
        wait_cycles(5);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.data",  32'(data),  32'h0);
        chk("rst.pulses", 32'({perr, ferr, ovf}), 32'd0);
        reset_n = 1'b1;
        wait_cycles(5);

        // Good 0x76 with consumer stalled
        snap_errs();
        send_good(8'h76);
        chk("f76.valid", 32'(valid), 32'd1);
        chk("f76.data",  32'(data),  32'h76);
        chk("f76.count", 32'(count), 32'd1);
        chk_errs("f76", 0, 0, 0);
        pop_expect("f76.pop", 8'h76);
        chk("f76.empty", 32'(valid), 32'd0);

        // Parity error then a good 0x00
        snap_errs();
        send_frame(8'h00, 1'b0, 1'b1);
        chk("par.valid", 32'(valid), 32'd0);
        chk_errs("par", 1, 0, 0);
        send_good(8'h00);
        chk("p00.count", 32'(count), 32'd1);
        pop_expect("p00.pop", 8'h00);

        // 3-cycle glitch with data low must not start a frame
        snap_errs();
        ps2_data = 1'b0;
        #100;
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(50);
        ps2_data = 1'b1;
        wait_cycles(20);
        chk("glt.valid", 32'(valid), 32'd0);
        send_good(8'hAA);
        chk("glt.count", 32'(count), 32'd1);
        chk_errs("glt", 0, 0, 0);
        pop_expect("glt.pop", 8'hAA);

        // Partial frame abandoned by the watchdog
        snap_errs();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wait_cycles(TIMEOUT + 100);
        chk_errs("tmo", 0, 1, 0);
        chk("tmo.valid", 32'(valid), 32'd0);
        send_good(8'h5A);
        chk_errs("tmo2", 0, 1, 0);
        pop_expect("tmo.pop", 8'h5A);

        // Overflow: five bytes into four entries
        snap_errs();
        for (int b = 1; b <= 5; b++) send_good(8'(b));
        chk("ovf.count", 32'(count), 32'd4);
        chk_errs("ovf", 0, 0, 1);
        for (int b = 1; b <= 4; b++) pop_expect("ovf.pop", 8'(b));
        chk("ovf.empty", 32'(valid), 32'd0);
        chk("ovf.cnt0",  32'(count), 32'd0);
        chk("ovf.hold",  32'(data),  32'h04);

`ifdef PS2_RX_ERR_COUNT_EN
        chk("errcnt", 32'(err_count), 32'd3);
`endif

        // Reset in the middle of a 0x33 frame
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'(8'h33 >> i));
        reset_n = 1'b0;
        wait_cycles(4);
        reset_n = 1'b1;
        wait_cycles(20);
        snap_errs();
        chk("rmf.valid", 32'(valid), 32'd0);
        chk("rmf.data",  32'(data),  32'h0);
`ifdef PS2_RX_ERR_COUNT_EN
        chk("rmf.errcnt", 32'(err_count), 32'd0);
`endif
        send_good(8'h44);
        chk("rmf.count", 32'(count), 32'd1);
        pop_expect("rmf.pop", 8'h44);
        chk("rmf.empty", 32'(valid), 32'd0);
        chk_errs("rmf", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
